// File: rtl/ll_tx_push_ctrl_if.sv
// Signal bundle between the TX push controller and the link / TX FIFO side.
// The controller attaches through the slave modport; the driving side uses master.
interface ll_tx_push_ctrl_if #(
  parameter int unsigned CRED_WIDTH = 4
);
  logic                  tx_online;
  logic                  tx_i_push_ovrd;
  logic                  txfifo_i_has_data;
  logic                  rx_i_credit;
  logic                  txfifo_i_pop;
  logic                  tx_i_pushbit;
  logic [CRED_WIDTH-1:0] tx_credit_count;
  logic                  tx_credit_err;

  modport master (
    output tx_online, tx_i_push_ovrd, txfifo_i_has_data, rx_i_credit,
    input  txfifo_i_pop, tx_i_pushbit, tx_credit_count, tx_credit_err
  );

  modport slave (
    input  tx_online, tx_i_push_ovrd, txfifo_i_has_data, rx_i_credit,
    output txfifo_i_pop, tx_i_pushbit, tx_credit_count, tx_credit_err
  );
endinterface

// File: rtl/ll_tx_push_ctrl.sv
// TX push control for one logical link: pops the TX FIFO and registers the push bit.
// Credit flow control is compiled in only when LL_TX_CREDIT_EN is defined.
module ll_tx_push_ctrl #(
  parameter int unsigned CRED_WIDTH = 4,
  parameter int unsigned INIT_CRED  = 8
) (
  input  logic             clk_wr,
  input  logic             rst_wr,
  ll_tx_push_ctrl_if.slave link
);

  typedef enum logic [1:0] {
    OFFLINE = 2'd0,
    LOAD    = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  localparam logic [CRED_WIDTH-1:0] CRED_ZERO = {CRED_WIDTH{1'b0}};
  localparam logic [CRED_WIDTH-1:0] CRED_INIT = CRED_WIDTH'(INIT_CRED);

  state_t state_r;
  state_t state_nxt_s;
  logic   pop_s;
  logic   pushbit_r;
  logic   credit_ok_s;

  // Next state and pop strobe; reset or loss of online blocks the pop in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    if (rst_wr || !link.tx_online) begin
      state_nxt_s = OFFLINE;
      pop_s       = 1'b0;
    end else begin
      case (state_r)
        OFFLINE: state_nxt_s = LOAD;
        LOAD:    state_nxt_s = ACTIVE;
        ACTIVE: begin
          state_nxt_s = ACTIVE;
          pop_s       = link.txfifo_i_has_data & credit_ok_s & ~link.tx_i_push_ovrd;
        end
        default: state_nxt_s = OFFLINE;
      endcase
    end
  end

  // State register and push bit, which lines up with FIFO read data one cycle after the pop.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state_r   <= OFFLINE;
      pushbit_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pushbit_r <= pop_s;
    end
  end

`ifdef LL_TX_CREDIT_EN
  localparam logic [CRED_WIDTH-1:0] CRED_MAX = {CRED_WIDTH{1'b1}};
  localparam logic [CRED_WIDTH-1:0] CRED_ONE = {{(CRED_WIDTH-1){1'b0}}, 1'b1};

  logic [CRED_WIDTH-1:0] count_r;
  logic [CRED_WIDTH-1:0] count_nxt_s;
  logic                  err_r;
  logic                  err_set_s;

  assign credit_ok_s = (count_r != CRED_ZERO);

  // Credit bookkeeping; a credit arriving at zero only enables a pop from the following cycle.
  always_comb begin
    count_nxt_s = count_r;
    err_set_s   = 1'b0;
    if (state_nxt_s == OFFLINE) begin
      count_nxt_s = CRED_ZERO;
    end else if (state_r == LOAD) begin
      count_nxt_s = CRED_INIT;
    end else if (state_r == ACTIVE) begin
      case ({link.rx_i_credit, pop_s})
        2'b10: begin
          if (count_r == CRED_MAX) begin
            count_nxt_s = CRED_MAX;
            err_set_s   = 1'b1;
          end else begin
            count_nxt_s = count_r + CRED_ONE;
          end
        end
        2'b01:   count_nxt_s = count_r - CRED_ONE;
        default: count_nxt_s = count_r;
      endcase
    end else begin
      count_nxt_s = CRED_ZERO;
    end
  end

  // Credit counter and sticky overflow flag; the flag is cleared only by reset.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      count_r <= CRED_ZERO;
      err_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      err_r   <= err_r | err_set_s;
    end
  end

  assign link.tx_credit_count = count_r;
  assign link.tx_credit_err   = err_r;
`else
  logic unused_cfg_s;

  assign credit_ok_s          = 1'b1;
  assign unused_cfg_s         = link.rx_i_credit ^ (^CRED_INIT);
  assign link.tx_credit_count = CRED_ZERO;
  assign link.tx_credit_err   = 1'b0;
`endif

  assign link.txfifo_i_pop = pop_s;
  assign link.tx_i_pushbit = pushbit_r;

endmodule

// File: tb/tb_ll_tx_push_ctrl.sv
// Self-checking bench for ll_tx_push_ctrl: a cycle model predicts pop/count/err and a
// queue carries each predicted pop forward as the expected push bit one cycle later.
module tb_ll_tx_push_ctrl;
  localparam int CW     = 4;
  localparam int IC     = 8;
  localparam int CMAX   = (1 << CW) - 1;
  localparam int M_OFF  = 0;
  localparam int M_LOAD = 1;
  localparam int M_ACT  = 2;

  logic          clk_wr = 1'b0;
  logic          rst_wr;
  int            n_cmp = 0;
  int            n_mis = 0;
  int            m_state;
  int            m_count;
  logic          m_err;
  logic          exp_q[$];
  logic          obs_pop, obs_pb, obs_err, exp_pop, exp_pb, exp_err;
  logic [CW-1:0] obs_cnt, exp_cnt;

  ll_tx_push_ctrl_if #(.CRED_WIDTH(CW)) link ();

  ll_tx_push_ctrl #(.CRED_WIDTH(CW), .INIT_CRED(IC)) dut (
    .clk_wr (clk_wr),
    .rst_wr (rst_wr),
    .link   (link)
  );

  always #5 clk_wr = ~clk_wr;

  task automatic drive(input logic rst, input logic online, input logic ovrd,
                       input logic data, input logic credit);
    rst_wr                 = rst;
    link.tx_online         = online;
    link.tx_i_push_ovrd    = ovrd;
    link.txfifo_i_has_data = data;
    link.rx_i_credit       = credit;
  endtask

  function automatic logic model_pop();
    if (rst_wr || !link.tx_online || m_state != M_ACT) return 1'b0;
`ifdef LL_TX_CREDIT_EN
    return link.txfifo_i_has_data && !link.tx_i_push_ovrd && (m_count != 0);
`else
    return link.txfifo_i_has_data && !link.tx_i_push_ovrd;
`endif
  endfunction

  task automatic model_advance(input logic p);
    if (rst_wr) begin
      m_state = M_OFF; m_count = 0; m_err = 1'b0;
    end else if (!link.tx_online) begin
      m_state = M_OFF; m_count = 0;
    end else if (m_state == M_OFF) begin
      m_state = M_LOAD;
    end else if (m_state == M_LOAD) begin
      m_state = M_ACT;
`ifdef LL_TX_CREDIT_EN
      m_count = IC;
`endif
    end else begin
`ifdef LL_TX_CREDIT_EN
      if (link.rx_i_credit && !p && m_count == CMAX) m_err = 1'b1;
      else m_count = m_count + int'(link.rx_i_credit) - int'(p);
`endif
    end
  endtask

  // One clock: sample the pop mid-cycle, advance DUT and model, sample registered outputs.
  task automatic cycle();
    #1;
    exp_pop = model_pop();
    obs_pop = link.txfifo_i_pop;
    exp_q.push_back(exp_pop);
    @(posedge clk_wr);
    model_advance(exp_pop);
    @(negedge clk_wr);
    exp_pb  = exp_q.pop_front();
    exp_cnt = m_count[CW-1:0];
    exp_err = m_err;
    obs_pb  = link.tx_i_pushbit;
    obs_cnt = link.tx_credit_count;
    obs_err = link.tx_credit_err;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if ({obs_pop, obs_pb, obs_cnt, obs_err} !== 8'h00) begin
        n_mis++;
        $display("FAIL reset cyc=%0d pop/push/cnt/err got=%b/%b/%0d/%b exp=0/0/0/0",
                 i, obs_pop, obs_pb, obs_cnt, obs_err);
      end
    end
  endtask

  task automatic test_startup();
    int pops = 0;
    int first = -1;
`ifdef LL_TX_CREDIT_EN
    int exp_pops = IC;
`else
    int exp_pops = 12;
`endif
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (obs_pop === 1'b1) begin
        pops++;
        if (first < 0) first = i;
      end
      n_cmp++;
      if ({obs_pop, obs_pb, obs_cnt, obs_err} !== {exp_pop, exp_pb, exp_cnt, exp_err}) begin
        n_mis++;
        $display("FAIL startup cyc=%0d pop/push/cnt/err got=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                 i, obs_pop, obs_pb, obs_cnt, obs_err, exp_pop, exp_pb, exp_cnt, exp_err);
      end
    end
    n_cmp++;
    if (first != 2) begin
      n_mis++;
      $display("FAIL startup_first_pop got=%0d exp=2", first);
    end
    n_cmp++;
    if (pops != exp_pops) begin
      n_mis++;
      $display("FAIL startup_pop_count got=%0d exp=%0d", pops, exp_pops);
    end
  endtask

`ifdef LL_TX_CREDIT_EN
  task automatic test_credit_zero();
    logic [2:0] seq;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, (i == 0) ? 1'b1 : 1'b0);
      cycle();
      seq[2-i] = obs_pop;
      n_cmp++;
      if ({obs_pop, obs_pb, obs_cnt, obs_err} !== {exp_pop, exp_pb, exp_cnt, exp_err}) begin
        n_mis++;
        $display("FAIL credit_zero cyc=%0d pop/push/cnt/err got=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                 i, obs_pop, obs_pb, obs_cnt, obs_err, exp_pop, exp_pb, exp_cnt, exp_err);
      end
    end
    n_cmp++;
    if (seq !== 3'b010) begin
      n_mis++;
      $display("FAIL credit_zero_seq got=%b exp=010", seq);
    end
  endtask

  task automatic test_simul_credit();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_cmp++;
      if (obs_pop !== 1'b1 || obs_cnt !== 4'd3 || obs_pb !== exp_pb) begin
        n_mis++;
        $display("FAIL simul_credit cyc=%0d pop/push/cnt got=%b/%b/%0d exp=1/%b/3",
                 i, obs_pop, obs_pb, obs_cnt, exp_pb);
      end
    end
  endtask

  task automatic test_overflow();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) begin
      cycle();
      n_cmp++;
      if ({obs_pop, obs_pb, obs_cnt, obs_err} !== {exp_pop, exp_pb, exp_cnt, exp_err}) begin
        n_mis++;
        $display("FAIL overflow cyc=%0d pop/push/cnt/err got=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                 i, obs_pop, obs_pb, obs_cnt, obs_err, exp_pop, exp_pb, exp_cnt, exp_err);
      end
    end
    n_cmp++;
    if (obs_cnt !== 4'd15 || obs_err !== 1'b1) begin
      n_mis++;
      $display("FAIL overflow_sat cnt/err got=%0d/%b exp=15/1", obs_cnt, obs_err);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    n_cmp++;
    if (obs_err !== 1'b1) begin
      n_mis++;
      $display("FAIL overflow_sticky err got=%b exp=1", obs_err);
    end
  endtask
`else
  task automatic test_macro_off();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      cycle();
      n_cmp++;
      if (obs_pop !== 1'b1 || obs_pb !== 1'b1 || obs_cnt !== 4'd0 || obs_err !== 1'b0) begin
        n_mis++;
        $display("FAIL macro_off cyc=%0d pop/push/cnt/err got=%b/%b/%0d/%b exp=1/1/0/0",
                 i, obs_pop, obs_pb, obs_cnt, obs_err);
      end
    end
  endtask
`endif

  task automatic test_offline();
    int first = -1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if ({obs_pop, obs_pb, obs_cnt, obs_err} !== {exp_pop, exp_pb, exp_cnt, exp_err}) begin
        n_mis++;
        $display("FAIL offline_pre cyc=%0d pop/push/cnt/err got=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                 i, obs_pop, obs_pb, obs_cnt, obs_err, exp_pop, exp_pb, exp_cnt, exp_err);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    n_cmp++;
    if (obs_pop !== 1'b0 || obs_cnt !== 4'd0) begin
      n_mis++;
      $display("FAIL offline_drop pop/cnt got=%b/%0d exp=0/0", obs_pop, obs_cnt);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (obs_pop === 1'b1 && first < 0) first = i;
      n_cmp++;
      if ({obs_pop, obs_pb, obs_cnt, obs_err} !== {exp_pop, exp_pb, exp_cnt, exp_err}) begin
        n_mis++;
        $display("FAIL offline_re cyc=%0d pop/push/cnt/err got=%b/%b/%0d/%b exp=%b/%b/%0d/%b",
                 i, obs_pop, obs_pb, obs_cnt, obs_err, exp_pop, exp_pb, exp_cnt, exp_err);
      end
    end
    n_cmp++;
    if (first != 2) begin
      n_mis++;
      $display("FAIL offline_first_pop got=%0d exp=2", first);
    end
  endtask

  task automatic test_override();
    logic [CW-1:0] cnt_before;
    cnt_before = obs_cnt;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++;
      if (obs_pop !== 1'b0 || obs_cnt !== cnt_before || obs_cnt !== exp_cnt) begin
        n_mis++;
        $display("FAIL override cyc=%0d pop/cnt got=%b/%0d exp=0/%0d",
                 i, obs_pop, obs_cnt, cnt_before);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle();
    n_cmp++;
    if (obs_pop !== 1'b1 || obs_pb !== 1'b1) begin
      n_mis++;
      $display("FAIL reset_mid_pre pop/push got=%b/%b exp=1/1", obs_pop, obs_pb);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle();
    n_cmp++;
    if ({obs_pop, obs_pb, obs_cnt, obs_err} !== 8'h00 ||
        {exp_pop, exp_pb, exp_cnt, exp_err} !== 8'h00) begin
      n_mis++;
      $display("FAIL reset_mid pop/push/cnt/err got=%b/%b/%0d/%b exp=0/0/0/0",
               obs_pop, obs_pb, obs_cnt, obs_err);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    m_state = M_OFF;
    m_count = 0;
    m_err   = 1'b0;
    @(negedge clk_wr);
    test_reset();
    test_startup();
`ifdef LL_TX_CREDIT_EN
    test_credit_zero();
    test_simul_credit();
    test_overflow();
`else
    test_macro_off();
`endif
    test_offline();
    test_override();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/ll_tx_push_ctrl.md
# ll_tx_push_ctrl

Transmit-side push control for one logical link. Holds a credit count of free entries in the far-end receive FIFO, pops the local TX FIFO when data and credit are both present, and drives the registered push bit that the far-end receive push logic qualifies into its FIFO write. Sits between the TX FIFO and the link data mux, in the write-clock domain.

## Interface
- CRED_WIDTH, 4, width of the credit counter
- INIT_CRED, 8, credits loaded on entering online (far-end RX FIFO depth); must be ≤ 2^CRED_WIDTH−1
- clk_wr  input  1  write-side clock
- rst_wr  input  1  reset; synchronous, active-high
- tx_online  input  1  link is online; level
- tx_i_push_ovrd  input  1  suppresses pops and pushes while high
- txfifo_i_has_data  input  1  TX FIFO not empty
- rx_i_credit  input  1  one-cycle credit return from the far end, one per freed entry
- txfifo_i_pop  output  1  combinational pop strobe to the TX FIFO
- tx_i_pushbit  output  1  registered push bit to the link
- tx_credit_count  output  CRED_WIDTH  current credit count
- tx_credit_err  output  1  sticky credit overflow flag

## Operation
- FSM states: OFFLINE, LOAD, ACTIVE. Reset state is OFFLINE.
- OFFLINE: count = 0; no pops. When tx_online = 1, go to LOAD.
- LOAD: lasts one cycle. Load count = INIT_CRED and ignore rx_i_credit. Go to ACTIVE.
- ACTIVE:
  - txfifo_i_pop = txfifo_i_has_data & (count ≠ 0) & !tx_i_push_ovrd.
  - Next count = count + rx_i_credit − txfifo_i_pop.
- Pop eligibility uses the current count. If count = 0 and a credit arrives in the same cycle, the credit adds but no pop occurs until the next cycle.
- Credit and pop in the same cycle leave count unchanged.
- Overflow: if count = 2^CRED_WIDTH−1, rx_i_credit = 1 and there is no pop, count saturates and tx_credit_err sets. tx_credit_err clears only on rst_wr.
- tx_online = 0 in any state: next state is OFFLINE, count clears, and no pop occurs that cycle. tx_online is qualified combinationally.
- txfifo_i_pop is 0 in OFFLINE and LOAD.

## Timing
- tx_i_pushbit is txfifo_i_pop registered one cycle, so it aligns with FIFO read data that appears one cycle after the pop.
- tx_credit_count is registered and reflects updates the cycle after the credit or pop.
- From tx_online rising, the first pop can occur 2 cycles later (the OFFLINE→LOAD cycle, then the LOAD cycle).
- Sustained throughput is one pop per cycle while credit and data are available.
- Reset values: txfifo_i_pop = 0, tx_i_pushbit = 0, tx_credit_count = 0, tx_credit_err = 0, state = OFFLINE.
- Reset mid-operation: all outputs reach reset values on the next edge. A pushbit in flight is dropped.

## Configuration
- LL_TX_CREDIT_EN defined: credit flow control as described above.
- LL_TX_CREDIT_EN undefined:
  - The credit counter is removed.
  - txfifo_i_pop = txfifo_i_has_data & !tx_i_push_ovrd in ACTIVE.
  - tx_credit_count ties to 0 and tx_credit_err ties to 0.
  - rx_i_credit is ignored.
  - The FSM and the pushbit register are unchanged.

## Test plan
- Startup and burst:
  - Stimulus: INIT_CRED = 8, online, FIFO always has data, no credits returned.
  - Response: pop on exactly 8 consecutive cycles starting 2 cycles after online. pushbit echoes each pop one cycle later. Count ends at 0 and pops stop.
- Credit at zero: count = 0, rx_i_credit pulse.
  - Response: count goes to 1 next cycle, then one pop, then count returns to 0.
- Simultaneous credit and pop at count = 3:
  - Response: count stays 3. Continuous pops with a credit every cycle hold the count steady.
- Overflow: CRED_WIDTH = 4, count = 15, credit with FIFO empty.
  - Response: count stays 15, tx_credit_err = 1 and stays set until rst_wr.
- Offline and override:
  - Drop tx_online with count = 5: pop = 0 that cycle, count = 0 next cycle, state is OFFLINE.
  - Hold tx_i_push_ovrd in ACTIVE with data and credit: no pops and the count is unchanged.
- Macro off: FIFO has data, no credits ever returned.
  - Response: pops every cycle in ACTIVE, tx_credit_count = 0.
